// File: rtl/mc_controller.sv
// Multicycle ARM control unit: sequences the shared ALU, memory port and register file,
// keeps NZCV and gates writes on the condition. `MC_CTRL_COND_SKIP_EN skips failed-condition paths.
module mc_controller (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:12] Instr,
   input  logic [3:0]   ALUFlags,
   output logic         PCWrite,
   output logic         MemWrite,
   output logic         RegWrite,
   output logic         IRWrite,
   output logic         AdrSrc,
   output logic [1:0]   RegSrc,
   output logic [1:0]   ImmSrc,
   output logic         ALUSrcA,
   output logic [1:0]   ALUSrcB,
   output logic [1:0]   ALUControl,
   output logic [1:0]   ResultSrc,
   output logic         InstrDone
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   state_t      state;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd, cond;
   logic [3:0]  flags;
   logic        cond_q, condex, dec_to_fetch;
   logic        n, z, c, v;
   logic        nextpc, branch, regw, memw, irw, aluop, done;
   logic [1:0]  alucontrol, flagw;
   logic        pcs;

   assign op    = Instr[27:26];
   assign funct = Instr[25:20];
   assign rd    = Instr[15:12];
   assign cond  = Instr[31:28];
   assign {n, z, c, v} = flags;

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};

   always_comb begin
      case (cond)
         4'd0:    condex = z;
         4'd1:    condex = ~z;
         4'd2:    condex = c;
         4'd3:    condex = ~c;
         4'd4:    condex = n;
         4'd5:    condex = ~n;
         4'd6:    condex = v;
         4'd7:    condex = ~v;
         4'd8:    condex = c & ~z;
         4'd9:    condex = ~c | z;
         4'd10:   condex = (n == v);
         4'd11:   condex = (n != v);
         4'd12:   condex = ~z & (n == v);
         4'd13:   condex = z | (n != v);
         4'd14:   condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

`ifdef MC_CTRL_COND_SKIP_EN
   assign dec_to_fetch = (op == 2'b11) | ~condex;
`else
   assign dec_to_fetch = (op == 2'b11);
`endif

   // ALU decode; the catch-all command is treated as ADD, so it also updates CV under S
   always_comb begin
      alucontrol = 2'b00;
      flagw      = 2'b00;
      if (aluop) begin
         case (funct[4:1])
            4'b0100: alucontrol = 2'b00;
            4'b0010: alucontrol = 2'b01;
            4'b0000: alucontrol = 2'b10;
            4'b1100: alucontrol = 2'b11;
            default: alucontrol = 2'b00;
         endcase
         flagw[1] = funct[0];
         flagw[0] = funct[0] & ~alucontrol[1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= FETCH;
         flags  <= 4'b0000;
         cond_q <= 1'b0;
      end else begin
         case (state)
            FETCH:  state <= DECODE;
            DECODE: begin
               cond_q <= condex;
               if (dec_to_fetch)       state <= FETCH;
               else if (op == 2'b01)   state <= MEMADR;
               else if (op == 2'b10)   state <= BRANCH;
               else if (funct[5])      state <= EXECI;
               else                    state <= EXECR;
            end
            MEMADR: state <= funct[0] ? MEMRD : MEMWR;
            MEMRD:  state <= MEMWB;
            EXECR, EXECI: begin
               state <= ALUWB;
               if (flagw[1] & cond_q) flags[3:2] <= ALUFlags[3:2];
               if (flagw[0] & cond_q) flags[1:0] <= ALUFlags[1:0];
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      nextpc    = 1'b0;
      branch    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      irw       = 1'b0;
      aluop     = 1'b0;
      done      = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (state)
         FETCH: begin
            irw = 1'b1; nextpc = 1'b1;
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            done = dec_to_fetch;
         end
         MEMADR: ALUSrcB = 2'b01;
         MEMRD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01; regw = 1'b1; done = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1; memw = 1'b1; done = 1'b1;
         end
         EXECR: aluop = 1'b1;
         EXECI: begin
            aluop = 1'b1; ALUSrcB = 2'b01;
         end
         ALUWB: begin
            regw = 1'b1; done = 1'b1;
         end
         BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; done = 1'b1;
         end
         default: ;
      endcase
   end

   assign ALUControl = alucontrol;
   assign pcs        = (regw & (rd == 4'd15)) | branch;

   // Write enables are held off combinationally so an asserted reset cancels any write at once
   assign PCWrite   = reset & (nextpc | (pcs & cond_q));
   assign RegWrite  = reset & regw & cond_q;
   assign MemWrite  = reset & memw & cond_q;
   assign IRWrite   = reset & irw;
   assign InstrDone = reset & done;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, reset corner sequences and a random
// instruction stream checked cycle-by-cycle against an instruction-level model.
module tb_mc_controller;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:12] Instr;
   logic [3:0]   ALUFlags;
   logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, InstrDone;
   logic [1:0]   RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;

   mc_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .InstrDone(InstrDone)
   );

   always #5 clk = ~clk;

`ifdef MC_CTRL_COND_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   int ncmp = 0;
   int nbad = 0;
   logic [3:0] mflags;

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  af;
      int          len;
      logic [2:0]  lastw;   // {PCWrite, RegWrite, MemWrite} in the InstrDone cycle
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      ncmp++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   function automatic bit cond_holds(input logic [3:0] cd, input logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (cd)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_cmd(input logic [5:0] fn);
      case (fn[4:1])
         4'b0100: return 2'd0;
         4'b0010: return 2'd1;
         4'b0000: return 2'd2;
         4'b1100: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic int ilen(input logic [31:0] w, input bit ok);
      if (w[27:26] == 2'b11) return 2;
      if (SKIP && !ok) return 2;
      if (w[27:26] == 2'b01) return w[20] ? 5 : 4;
      if (w[27:26] == 2'b00) return 4;
      return 3;
   endfunction

   // Expected outputs for cycle k of an instruction, laid out by instruction class
   function automatic logic [16:0] exp_vec(input logic [31:0] w, input int k, input bit ok, input int len);
      logic [1:0] op, sb, ac, rs;
      logic [5:0] fn;
      logic pcw, mw, rw, irw, adr, sa, rd15;
      op = w[27:26]; fn = w[25:20]; rd15 = (w[15:12] == 4'hF);
      {pcw, mw, rw, irw, adr, sa} = '0; sb = 0; ac = 0; rs = 0;
      if (k == 0) begin irw = 1; pcw = 1; sa = 1; sb = 2; rs = 2; end
      else if (k == 1) begin sa = 1; sb = 2; rs = 2; end
      else if (op == 2'b01) begin
         if (k == 2) sb = 1;
         else if (k == 3) begin adr = 1; mw = ok && !fn[0]; end
         else begin rs = 1; rw = ok; pcw = ok && rd15; end
      end else if (op == 2'b00) begin
         if (k == 2) begin sb = fn[5] ? 2'd1 : 2'd0; ac = alu_cmd(fn); end
         else begin rw = ok; pcw = ok && rd15; end
      end else begin
         sb = 1; rs = 2; pcw = ok;
      end
      return {pcw, mw, rw, irw, adr, op == 2'b01, op == 2'b10, op, sa, sb, ac, rs, k == len - 1};
   endfunction

   function automatic logic [16:0] obs();
      return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
              ALUSrcA, ALUSrcB, ALUControl, ResultSrc, InstrDone};
   endfunction

   task automatic run_instr(input logic [31:0] w, input bit rnd, input logic [3:0] af,
                            output int ncyc, output logic [2:0] lastw);
      bit ok;
      int len;
      logic [3:0] afx, afe;
      ok = cond_holds(w[31:28], mflags);
      len = ilen(w, ok);
      ncyc = 0; lastw = 3'b000; afe = 4'b0;
      for (int k = 0; k < len; k++) begin
         Instr = w[31:12];
         afx = rnd ? 4'($urandom) : af;
         ALUFlags = afx;
         @(negedge clk);
         chk($sformatf("cyc%0d ins=%h", k, w), 32'(obs()), 32'(exp_vec(w, k, ok, len)));
         if (k == 2) afe = afx;
         if (InstrDone && ncyc == 0) begin
            ncyc = k + 1;
            lastw = {PCWrite, RegWrite, MemWrite};
         end
         @(posedge clk); #1;
      end
      if (w[27:26] == 2'b00 && ok && w[20]) begin
         mflags[3:2] = afe[3:2];
         if (alu_cmd(w[25:20]) < 2) mflags[1:0] = afe[1:0];
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, " enables"}, 32'({PCWrite, MemWrite, RegWrite, IRWrite, InstrDone}), 32'd0);
      chk({nm, " selects"}, 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'({1'b0, 1'b1, 2'd2, 2'd2}));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nc;
      logic [2:0] lw;
      logic [31:0] w;

      tv[0]  = '{32'hE0921003, 4'b0110, 4, 3'b010};                       // ADDS -> flags 0110
      tv[1]  = '{32'h0A000000, 4'b0000, 3, 3'b100};                       // BEQ, Z=1
      tv[2]  = '{32'h1A000000, 4'b0000, SKIP ? 2 : 3, 3'b000};            // BNE, Z=1
      tv[3]  = '{32'hE5910004, 4'b1111, 5, 3'b010};                       // LDR
      tv[4]  = '{32'hE5810004, 4'b1111, 4, 3'b001};                       // STR
      tv[5]  = '{32'hE04FF001, 4'b1111, 4, 3'b110};                       // SUB to R15
      tv[6]  = '{32'hEC000000, 4'b1111, 2, 3'b000};                       // Op=11
      tv[7]  = '{32'hF0921003, 4'b1111, SKIP ? 2 : 4, 3'b000};            // never condition
      tv[8]  = '{32'hE0521003, 4'b1000, 4, 3'b010};                       // SUBS -> flags 1000
      tv[9]  = '{32'h4A000000, 4'b0000, 3, 3'b100};                       // BMI taken
      tv[10] = '{32'h0A000000, 4'b0000, SKIP ? 2 : 3, 3'b000};            // BEQ, Z=0
      tv[11] = '{32'hBA000000, 4'b0000, 3, 3'b100};                       // BLT taken

      reset = 1'b0; Instr = '0; ALUFlags = '0; mflags = 4'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset_outputs($sformatf("reset%0d", i));
      end
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_instr(tv[i].ins, 1'b0, tv[i].af, nc, lw);
         chk($sformatf("vec%0d len", i), 32'(nc), 32'(tv[i].len));
         chk($sformatf("vec%0d writes", i), 32'(lw), 32'(tv[i].lastw));
      end

      // Set Z, then abort an LDR in MEMWB with reset: no write and flags cleared
      run_instr(32'hE0921003, 1'b0, 4'b0100, nc, lw);
      Instr = 20'hE5910; ALUFlags = 4'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
      end
      chk("memwb regwrite", 32'(RegWrite), 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(posedge clk); #1;
      chk_reset_outputs("midreset hold");
      reset = 1'b1;
      mflags = 4'b0;
      run_instr(32'h0A000000, 1'b0, 4'b0000, nc, lw);
      chk("beq after reset len", 32'(nc), SKIP ? 32'd2 : 32'd3);
      chk("beq after reset writes", 32'(lw), 32'd0);

      for (int i = 0; i < 300; i++) begin
         w = $urandom;
         if ($urandom_range(0, 3) == 0) w[31:28] = 4'hE;
         if ($urandom_range(0, 15) == 0) w[27:26] = 2'b11;
         else w[27:26] = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
         if ($urandom_range(0, 1) == 0) w[24:21] = $urandom_range(0, 1) ? 4'b0100 : 4'b0010;
         run_instr(w, 1'b1, 4'b0, nc, lw);
         chk($sformatf("rand%0d len", i), 32'(nc), 32'(ilen(w, 1'b1) == 2 ? nc : ilen(w, 1'b1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
